// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the EX/MEM commit slice.
//   - MIPS opcode and R-type funct encodings recognised by the commit stage
//   - bit positions inside the 3-bit ALU flag bus
//   - commit FSM state encodings
//   - op_class_t: the per-instruction classification produced by ex_op_decode
//   - branch_target(): PC-relative branch destination helper
// No ports; imported by ex_op_decode and ex_commit_stage.
// ----------------------------------------------------------------------------
package ex_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Positions inside the ALU flag bus
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    // Commit FSM states: normal flow, or holding a pending overflow trap
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    // Everything the commit stage needs to know about an instruction
    typedef struct packed {
        logic is_rtype;   // destination comes from rd instead of rt
        logic is_slt;     // value is the less-than flag, not the ALU result
        logic is_branch;  // beq/bne: produces a branch decision only
        logic is_load;    // lw
        logic is_store;   // sw
        logic can_ovf;    // signed add/sub/addi: overflow flag raises a trap
        logic known;      // recognised encoding; unknown ones are dropped
    } op_class_t;

    // Branch destination: PC+4 plus the sign-extended word offset
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm16);
        branch_target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ex_op_decode.sv
// ----------------------------------------------------------------------------
// ex_op_decode
// Purely combinational classification of the instruction that was sent to
// the ALU, so the commit stage knows how to treat the result.
// Ports:
//   i_opcode  in  6   instr[31:26]
//   i_funct   in  6   instr[5:0] (only meaningful for R-type)
//   o_class   out     op_class_t flags (see ex_pkg)
// ----------------------------------------------------------------------------
module ex_op_decode
    import ex_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output op_class_t  o_class
);

    // Unrecognised encodings fall through with known=0 so the top can
    // accept and silently drop them.
    always_comb begin
        o_class = '0;
        if (i_opcode == OP_RTYPE) begin
            o_class.is_rtype = 1'b1;
            case (i_funct)
                FN_ADD, FN_SUB: begin
                    o_class.known   = 1'b1;
                    o_class.can_ovf = 1'b1;
                end
                FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                    o_class.known = 1'b1;
                end
                FN_SLT, FN_SLTU: begin
                    o_class.known  = 1'b1;
                    o_class.is_slt = 1'b1;
                end
                default: begin
                end
            endcase
        end else begin
            case (i_opcode)
                OP_ADDI: begin
                    o_class.known   = 1'b1;
                    o_class.can_ovf = 1'b1;
                end
                OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    o_class.known = 1'b1;
                end
                OP_SLTI, OP_SLTIU: begin
                    o_class.known  = 1'b1;
                    o_class.is_slt = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    o_class.known     = 1'b1;
                    o_class.is_branch = 1'b1;
                end
                OP_LW: begin
                    o_class.known   = 1'b1;
                    o_class.is_load = 1'b1;
                end
                OP_SW: begin
                    o_class.known    = 1'b1;
                    o_class.is_store = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_commit_stage.sv
// ----------------------------------------------------------------------------
// ex_commit_stage
// Consumer side of the ALU. Registers the ALU result into the EX/MEM
// boundary, resolves beq/bne, forms slt 0/1 values, selects the writeback
// register and turns signed add/sub/addi overflow into a held trap.
// Only DATA_W = 32 is supported.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_in_valid/o_in_ready        ID/EX handshake
//   i_in_instr, i_in_pc4         instruction word and its PC+4
//   i_in_store_data              rt value for sw
//   i_in_alu_result, i_in_alu_flags   ALU outputs ([2] zero, [1] neg, [0] ovf)
//   i_flush                      squash held entry and this cycle's acceptance
//   o_out_valid/i_out_ready      EX/MEM handshake
//   o_out_addr_value             memory address or writeback value
//   o_out_store_data             sw data
//   o_out_wb_reg, o_out_wb_en    destination register and its write enable
//   o_out_mem_read/o_out_mem_write    lw / sw
//   o_br_taken, o_br_target      one-cycle taken-branch pulse and target
//   o_exc_ovf, o_exc_pc, i_exc_ack    overflow trap, its PC, and its clear
// ----------------------------------------------------------------------------
module ex_commit_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_in_instr,
    input  logic [DATA_W-1:0] i_in_pc4,
    input  logic [DATA_W-1:0] i_in_store_data,
    input  logic [DATA_W-1:0] i_in_alu_result,
    input  logic [2:0]        i_in_alu_flags,
    input  logic              i_flush,

    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_addr_value,
    output logic [DATA_W-1:0] o_out_store_data,
    output logic [REG_W-1:0]  o_out_wb_reg,
    output logic              o_out_wb_en,
    output logic              o_out_mem_read,
    output logic              o_out_mem_write,

    output logic              o_br_taken,
    output logic [DATA_W-1:0] o_br_target,

    output logic              o_exc_ovf,
    output logic [DATA_W-1:0] o_exc_pc,
    input  logic              i_exc_ack
);

    logic [0:0]        r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_addr_value;
    logic [DATA_W-1:0] r_out_store_data;
    logic [REG_W-1:0]  r_out_wb_reg;
    logic              r_out_wb_en;
    logic              r_out_mem_read;
    logic              r_out_mem_write;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;
    logic [DATA_W-1:0] r_exc_pc;

    op_class_t         w_class;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_ovf;
    logic              w_trap;
    logic              w_entry;
    logic              w_br_take;
    logic [REG_W-1:0]  w_dest;
    logic [DATA_W-1:0] w_value;
    logic              w_wb_en;
    logic [DATA_W-1:0] w_br_target;

    ex_op_decode u_decode (
        .i_opcode (i_in_instr[31:26]),
        .i_funct  (i_in_instr[5:0]),
        .o_class  (w_class)
    );

    // Acceptance: only in RUN, never while flushing, and only when the
    // output slot is empty or being drained this very cycle.
    always_comb begin
        w_in_ready = (r_state == ST_RUN) & ~i_flush & (~r_out_valid | i_out_ready);
        w_accept   = i_in_valid & w_in_ready;
    end

    // Classify what an accepted instruction turns into. Branches, trapping
    // overflows and unknown encodings all leave the output slot empty.
    always_comb begin
        w_ovf     = w_class.can_ovf & i_in_alu_flags[FLAG_OVF];
        w_trap    = w_accept & w_ovf;
        w_entry   = w_accept & w_class.known & ~w_class.is_branch & ~w_ovf;
        w_br_take = w_accept & w_class.is_branch & i_in_alu_flags[FLAG_ZERO];
    end

    // Payload formation. R-type writes rd, I-type writes rt; writes to r0
    // are suppressed, and stores never write back.
    always_comb begin
        w_dest      = w_class.is_rtype ? i_in_instr[15:11] : i_in_instr[20:16];
        w_value     = w_class.is_slt ? {{(DATA_W-1){1'b0}}, i_in_alu_flags[FLAG_NEG]}
                                     : i_in_alu_result;
        w_wb_en     = ~w_class.is_store & (w_dest != '0);
        w_br_target = branch_target(i_in_pc4, i_in_instr[15:0]);
    end

    // Commit FSM. A trap parks the stage (in_ready=0) until software
    // acknowledges it; flush deliberately has no effect here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_trap) begin
                        r_state <= ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    if (i_exc_ack) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Trapping instruction's own PC is captured at acceptance and held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_pc <= '0;
        end else if (w_trap) begin
            r_exc_pc <= i_in_pc4 - 32'd4;
        end
    end

    // EX/MEM output slot. A new entry overwrites the slot even while the
    // old one is being consumed, so back-to-back transfers have no bubble.
    // The payload only changes on a load, which keeps it stable during a
    // stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_addr_value <= '0;
            r_out_store_data <= '0;
            r_out_wb_reg     <= '0;
            r_out_wb_en      <= 1'b0;
            r_out_mem_read   <= 1'b0;
            r_out_mem_write  <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_entry) begin
            r_out_valid      <= 1'b1;
            r_out_addr_value <= w_value;
            r_out_store_data <= i_in_store_data;
            r_out_wb_reg     <= w_dest;
            r_out_wb_en      <= w_wb_en;
            r_out_mem_read   <= w_class.is_load;
            r_out_mem_write  <= w_class.is_store;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Taken-branch pulse lasts one cycle; the target is held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_taken <= w_br_take;
            if (w_br_take) begin
                r_br_target <= w_br_target;
            end
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_out_valid      = r_out_valid;
    assign o_out_addr_value = r_out_addr_value;
    assign o_out_store_data = r_out_store_data;
    assign o_out_wb_reg     = r_out_wb_reg;
    assign o_out_wb_en      = r_out_wb_en;
    assign o_out_mem_read   = r_out_mem_read;
    assign o_out_mem_write  = r_out_mem_write;
    assign o_br_taken       = r_br_taken;
    assign o_br_target      = r_br_target;
    assign o_exc_ovf        = (r_state == ST_TRAP);
    assign o_exc_pc         = r_exc_pc;

endmodule

// File: tb/tb_ex_commit_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_commit_stage
// Drives directed scenarios followed by random traffic into ex_commit_stage.
// A reference model classifies each accepted instruction by mnemonic and
// pushes the expected EX/MEM entry into a queue; an independent monitor
// compares every presented entry against the queue head and pops it on a
// completed handshake. Branch, trap and handshake outputs are compared
// against the model every cycle.
// ----------------------------------------------------------------------------
module tb_ex_commit_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInstr;
    logic [31:0] inPc4;
    logic [31:0] inStoreData;
    logic [31:0] inAluResult;
    logic [2:0]  inAluFlags;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outAddrValue;
    logic [31:0] outStoreData;
    logic [4:0]  outWbReg;
    logic        outWbEn;
    logic        outMemRead;
    logic        outMemWrite;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        excOvf;
    logic [31:0] excPc;
    logic        excAck;

    always #5 clk = ~clk;

    ex_commit_stage dut (
        .clk              (clk),
        .reset            (reset),
        .i_in_valid       (inValid),
        .o_in_ready       (inReady),
        .i_in_instr       (inInstr),
        .i_in_pc4         (inPc4),
        .i_in_store_data  (inStoreData),
        .i_in_alu_result  (inAluResult),
        .i_in_alu_flags   (inAluFlags),
        .i_flush          (flush),
        .o_out_valid      (outValid),
        .i_out_ready      (outReady),
        .o_out_addr_value (outAddrValue),
        .o_out_store_data (outStoreData),
        .o_out_wb_reg     (outWbReg),
        .o_out_wb_en      (outWbEn),
        .o_out_mem_read   (outMemRead),
        .o_out_mem_write  (outMemWrite),
        .o_br_taken       (brTaken),
        .o_br_target      (brTarget),
        .o_exc_ovf        (excOvf),
        .o_exc_pc         (excPc),
        .i_exc_ack        (excAck)
    );

    typedef enum {K_ALU, K_SLT, K_SIGNED_ADD, K_LOAD, K_STORE, K_BRANCH, K_UNKNOWN} kind_e;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] storeData;
        logic [4:0]  wbReg;
        logic        wbEn;
        logic        memRead;
        logic        memWrite;
    } entry_t;

    entry_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mHeld = 1'b0;
    bit          mTrap = 1'b0;
    bit          mBr = 1'b0;
    logic [31:0] mBrTarget = 32'h0;
    logic [31:0] mExcPc = 32'h0;

    logic [5:0] rFuncts [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] iOps    [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] badOps  [4]  = '{6'h02, 6'h03, 6'h10, 6'h3F};
    logic [5:0] badFns  [4]  = '{6'h08, 6'h18, 6'h1A, 6'h3F};

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        logic [4:0] a, b, c;
        a = 5'(rs);
        b = 5'(rt);
        c = 5'(rd);
        rtype = {6'h00, a, b, c, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] a, b;
        a = 5'(rs);
        b = 5'(rt);
        itype = {op, a, b, imm};
    endfunction

    // Mnemonic-level classification of the MIPS subset the stage handles
    function automatic void classify(input logic [31:0] instr, output kind_e kind, output bit isR);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        isR = (op == 6'h00);
        if (isR) begin
            case (fn)
                6'h20, 6'h22:                           kind = K_SIGNED_ADD;   // add, sub
                6'h2A, 6'h2B:                           kind = K_SLT;          // slt, sltu
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: kind = K_ALU;
                default:                                kind = K_UNKNOWN;
            endcase
        end else begin
            case (op)
                6'h08:                             kind = K_SIGNED_ADD;        // addi
                6'h0A, 6'h0B:                      kind = K_SLT;               // slti, sltiu
                6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: kind = K_ALU;
                6'h23:                             kind = K_LOAD;
                6'h2B:                             kind = K_STORE;
                6'h04, 6'h05:                      kind = K_BRANCH;
                default:                           kind = K_UNKNOWN;
            endcase
        end
    endfunction

    function automatic bit expectedReady();
        return !mTrap && !flush && (!mHeld || outReady);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("in_ready",  {31'b0, inReady},  {31'b0, expectedReady()});
        checkVal("out_valid", {31'b0, outValid}, {31'b0, mHeld});
        checkVal("br_taken",  {31'b0, brTaken},  {31'b0, mBr});
        checkVal("br_target", brTarget, mBrTarget);
        checkVal("exc_ovf",   {31'b0, excOvf},   {31'b0, mTrap});
        checkVal("exc_pc",    excPc, mExcPc);
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle
    task automatic modelUpdate();
        kind_e       kind;
        bit          isR;
        bit          accept;
        entry_t      e;
        int          offset;
        if (reset) begin
            mHeld = 1'b0; mTrap = 1'b0; mBr = 1'b0;
            mBrTarget = 32'h0; mExcPc = 32'h0;
            expQ.delete();
            return;
        end
        accept = inValid && expectedReady();
        mBr = 1'b0;
        if (flush) begin
            if (mHeld) expQ.delete();
            mHeld = 1'b0;
        end else if (mHeld && outReady) begin
            mHeld = 1'b0;
        end
        if (mTrap && excAck) mTrap = 1'b0;
        if (accept) begin
            classify(inInstr, kind, isR);
            if (kind == K_BRANCH) begin
                if (inAluFlags[2]) begin
                    offset = $signed(inInstr[15:0]);
                    mBr = 1'b1;
                    mBrTarget = inPc4 + 32'(offset * 4);
                end
            end else if (kind == K_SIGNED_ADD && inAluFlags[0]) begin
                mTrap = 1'b1;
                mExcPc = inPc4 - 32'd4;
            end else if (kind != K_UNKNOWN) begin
                e.value     = (kind == K_SLT) ? {31'b0, inAluFlags[1]} : inAluResult;
                e.storeData = inStoreData;
                e.wbReg     = isR ? inInstr[15:11] : inInstr[20:16];
                e.wbEn      = (kind != K_STORE) && (e.wbReg != 5'd0);
                e.memRead   = (kind == K_LOAD);
                e.memWrite  = (kind == K_STORE);
                expQ.push_back(e);
                mHeld = 1'b1;
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] res,
                                 input logic [2:0] flags, input logic [31:0] pc4,
                                 input logic fl, input logic rdy, input logic ack);
        inValid     = v;
        inInstr     = instr;
        inAluResult = res;
        inAluFlags  = flags;
        inPc4       = pc4;
        inStoreData = $urandom;
        flush       = fl;
        outReady    = rdy;
        excAck      = ack;
        stepCycle();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    function automatic logic [31:0] randomInstr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 4)
            return rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         rFuncts[$urandom_range(0, 15)]);
        else if (sel < 8)
            return itype(iOps[$urandom_range(0, 11)], $urandom_range(0, 31), $urandom_range(0, 31),
                         16'($urandom));
        else if (sel == 8)
            return itype(badOps[$urandom_range(0, 3)], $urandom_range(0, 31), $urandom_range(0, 31),
                         16'($urandom));
        else
            return rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         badFns[$urandom_range(0, 3)]);
    endfunction

    // Monitor: compares every presented entry with the scoreboard head
    always @(negedge clk) begin
        entry_t act;
        if (outValid === 1'b1) begin
            act = {outAddrValue, outStoreData, outWbReg, outWbEn, outMemRead, outMemWrite};
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL entry: got unexpected entry %h expected none at %0t", act, $time);
            end else begin
                if (act !== expQ[0]) begin
                    errors++;
                    $display("[TB] FAIL entry: got %h expected %h at %0t", act, expQ[0], $time);
                end
                if (outReady === 1'b1) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic        fl;
        logic        rdy;
        logic        ack;
        logic [2:0]  fg;
        reset = 1'b1;
        inValid = 1'b0; inInstr = '0; inPc4 = '0; inStoreData = '0;
        inAluResult = '0; inAluFlags = '0; flush = 1'b0; outReady = 1'b0; excAck = 1'b0;
        idle(2, 1'b0);
        reset = 1'b0;

        // addu r3 <- 5
        applyStimulus(1'b1, rtype(1, 2, 3, 6'h21), 32'h5, 3'b000, 32'h40, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);

        // slt with less-than set, then sltiu with it clear
        applyStimulus(1'b1, rtype(4, 5, 6, 6'h2A), 32'hFFFF_FFFE, 3'b010, 32'h44, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, itype(6'h0B, 1, 7, 16'h0009), 32'h123, 3'b000, 32'h48, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);

        // beq taken: target 0x100 + 4*4
        applyStimulus(1'b1, itype(6'h04, 1, 2, 16'h0004), 32'h0, 3'b100, 32'h100, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // add overflow -> trap, stays blocked, then acknowledged
        applyStimulus(1'b1, rtype(1, 2, 8, 6'h20), 32'h8000_0000, 3'b001, 32'h204, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, rtype(1, 2, 9, 6'h21), 32'h7, 3'b000, 32'h208, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, rtype(1, 2, 9, 6'h21), 32'h7, 3'b000, 32'h208, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // sw stalled for three cycles, then back-to-back replacement by lw
        applyStimulus(1'b1, itype(6'h2B, 1, 9, 16'h0010), 32'h1000, 3'b000, 32'h300, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, itype(6'h23, 2, 10, 16'h0020), 32'h2000, 3'b000, 32'h304, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, itype(6'h23, 2, 10, 16'h0020), 32'h2000, 3'b000, 32'h304, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);

        // flush beats in_valid; then flush squashes a held entry
        applyStimulus(1'b1, itype(6'h23, 3, 11, 16'h0), 32'h3000, 3'b000, 32'h308, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, itype(6'h23, 3, 11, 16'h0), 32'h3000, 3'b000, 32'h308, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, itype(6'h05, 3, 4, 16'hFFFC), 32'h0, 3'b100, 32'h30C, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // reset while trapped, and reset while an entry is stalled
        applyStimulus(1'b1, itype(6'h08, 1, 12, 16'h7FFF), 32'h0, 3'b001, 32'h404, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, rtype(1, 2, 13, 6'h25), 32'hABCD, 3'b000, 32'h408, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        idle(1, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            fl  = ($urandom_range(0, 11) == 0);
            rdy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 3) == 0);
            fg  = {1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0)};
            applyStimulus(1'($urandom_range(0, 3) != 0), randomInstr(), $urandom, fg,
                          {$urandom_range(0, 32'h3FFF), 2'b00}, fl, rdy, ack);
        end

        // Drain and confirm every expected entry was delivered
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        checkVal("drain", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
